// File: rtl/ysyx_25010008_lsu.sv
// Load/store unit: one memory operation at a time, issued as a single-beat AXI4-Lite
// transaction, with lane alignment, strobes, load extension and misalignment trapping.
module ysyx_25010008_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_wen,
  input  logic [2:0]  in_funct3,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic        out_err,
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  output logic        rready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rvalid,
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  output logic        bready,
  input  logic [1:0]  bresp,
  input  logic        bvalid
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_AR = 3'd1, S_R = 3'd2, S_WR = 3'd3, S_B = 3'd4, S_DONE = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        aw_done_q, aw_done_d;
  logic        w_done_q, w_done_d;
  logic        aw_fire, w_fire;

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = off[0];
      default: misaligned = (off != 2'b00);
    endcase
  endfunction

  function automatic logic [3:0] strobe(input logic [2:0] f3, input logic [1:0] off);
    logic [3:0] base;
    case (f3[1:0])
      2'b00:   base = 4'b0001;
      2'b01:   base = 4'b0011;
      default: base = 4'b1111;
    endcase
    strobe = base << off;
  endfunction

  // Bit 2 of funct3 selects zero extension for byte/half loads.
  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [31:0] d,
                                           input logic [1:0] off);
    logic [31:0] lane;
    lane = d >> {off, 3'b000};
    case (f3)
      3'b000:  load_ext = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_ext = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_ext = {24'h000000, lane[7:0]};
      3'b101:  load_ext = {16'h0000, lane[15:0]};
      default: load_ext = lane;
    endcase
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      f3_q      <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      wstrb_q   <= 4'd0;
      rdata_q   <= 32'd0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      err_q     <= err_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign aw_fire = (state_q == S_WR) && !aw_done_q && awready;
  assign w_fire  = (state_q == S_WR) && !w_done_q && wready;

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          f3_d      = in_funct3;
          addr_d    = in_addr;
          wdata_d   = in_wdata << {in_addr[1:0], 3'b000};
          wstrb_d   = strobe(in_funct3, in_addr[1:0]);
          rdata_d   = 32'd0;
          err_d     = 1'b0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (misaligned(in_funct3, in_addr[1:0])) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else if (in_wen) begin
            state_d = S_WR;
          end else begin
            state_d = S_AR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (arready) state_d = S_R;
        else         state_d = S_AR;
      end
      S_R: begin
        if (rvalid) begin
          rdata_d = load_ext(f3_q, rdata, addr_q[1:0]);
          err_d   = (rresp != 2'b00);
          state_d = S_DONE;
        end else begin
          state_d = S_R;
        end
      end
      S_WR: begin
        // Address and data handshakes complete independently, in either order.
        if (aw_fire) aw_done_d = 1'b1;
        else         aw_done_d = aw_done_q;
        if (w_fire) w_done_d = 1'b1;
        else        w_done_d = w_done_q;
        if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) state_d = S_B;
        else                                                 state_d = S_WR;
      end
      S_B: begin
        if (bvalid) begin
          rdata_d = 32'd0;
          err_d   = (bresp != 2'b00);
          state_d = S_DONE;
        end else begin
          state_d = S_B;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
        else           state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE:  in_ready = 1'b1;
      S_AR:    arvalid = 1'b1;
      S_R:     rready = 1'b1;
      S_WR: begin
        awvalid = !aw_done_q;
        wvalid  = !w_done_q;
      end
      S_B:     bready = 1'b1;
      S_DONE:  out_valid = 1'b1;
      default: in_ready = 1'b0;
    endcase
  end

  assign araddr    = addr_q;
  assign awaddr    = addr_q;
  assign arsize    = {1'b0, f3_q[1:0]};
  assign awsize    = {1'b0, f3_q[1:0]};
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign out_rdata = rdata_q;
  assign out_err   = err_q;

endmodule

// File: tb/tb_ysyx_25010008_lsu.sv
// Table-driven bench for ysyx_25010008_lsu with a behavioural AXI slave and a result scoreboard.
module tb_ysyx_25010008_lsu;

  logic        clock = 1'b0, reset = 1'b1;
  logic        in_valid = 1'b0, in_ready, in_wen = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [31:0] in_addr = 32'd0, in_wdata = 32'd0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_rdata;
  logic [31:0] araddr, awaddr, wdata;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready = 1'b0, rready, rvalid = 1'b0;
  logic [31:0] rdata = 32'd0;
  logic [1:0]  rresp = 2'd0, bresp = 2'd0;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0, bready, bvalid = 1'b0;
  logic [3:0]  wstrb;

  int checks = 0, errors = 0, cyc = 0;

  ysyx_25010008_lsu dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_wen(in_wen), .in_funct3(in_funct3),
    .in_addr(in_addr), .in_wdata(in_wdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
    .araddr(araddr), .arsize(arsize), .arvalid(arvalid), .arready(arready),
    .rready(rready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid),
    .awaddr(awaddr), .awsize(awsize), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bready(bready), .bresp(bresp), .bvalid(bvalid)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    bit          wen;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [1:0]  resp;
    int          ar_dly;
    int          aw_dly;
    int          w_dly;
    int          out_dly;
    logic [2:0]  e_size;
    logic [31:0] e_wdata;
    logic [3:0]  e_wstrb;
    logic [31:0] e_rdata;
    bit          e_err;
    bit          mis;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_op(input vec_t v);
    exp_t e;
    int   t0, n, aw_w, w_w, mx;
    bit   aw_done, w_done;
    logic [31:0] held;
    n = 0;
    while (!in_ready && n < 50) begin @(negedge clock); n++; end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1; in_wen = v.wen; in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wd;
    mx = (v.aw_dly > v.w_dly) ? v.aw_dly : v.w_dly;
    e.rdata = v.e_rdata;
    e.err   = v.e_err;
    e.lat   = v.mis ? 1 : (v.wen ? 3 + mx : 3 + v.ar_dly);
    sb.push_back(e);
    t0 = cyc;
    @(negedge clock);
    in_valid = 1'b0;
    if (v.mis) begin
      chk("mis_arvalid", arvalid, 0);
      chk("mis_awvalid", awvalid, 0);
    end else if (!v.wen) begin
      chk("arvalid", arvalid, 1);
      chk("araddr", araddr, v.addr);
      chk("arsize", arsize, v.e_size);
      for (int i = 0; i < v.ar_dly; i++) begin
        @(negedge clock);
        chk("arvalid_hold", arvalid, 1);
        chk("araddr_hold", araddr, v.addr);
      end
      arready = 1'b1;
      @(negedge clock);
      arready = 1'b0;
      chk("rready", rready, 1);
      rvalid = 1'b1; rdata = v.rd; rresp = v.resp;
      @(negedge clock);
      rvalid = 1'b0; rdata = 32'd0; rresp = 2'd0;
    end else begin
      chk("awaddr", awaddr, v.addr);
      chk("awsize", awsize, v.e_size);
      chk("wdata", wdata, v.e_wdata);
      chk("wstrb", wstrb, v.e_wstrb);
      aw_done = 0; w_done = 0; aw_w = 0; w_w = 0; n = 0;
      while (!(aw_done && w_done) && n < 50) begin
        chk("bready_early", bready, 0);
        if (!aw_done) begin
          chk("awvalid_hold", awvalid, 1);
          chk("awaddr_hold", awaddr, v.addr);
          awready = (aw_w == v.aw_dly);
        end else begin
          chk("awvalid_drop", awvalid, 0);
          awready = 1'b0;
        end
        if (!w_done) begin
          chk("wvalid_hold", wvalid, 1);
          chk("wdata_hold", wdata, v.e_wdata);
          wready = (w_w == v.w_dly);
        end else begin
          chk("wvalid_drop", wvalid, 0);
          wready = 1'b0;
        end
        @(negedge clock);
        if (awready) aw_done = 1; else aw_w++;
        if (wready) w_done = 1; else w_w++;
        n++;
      end
      awready = 1'b0; wready = 1'b0;
      chk("bready", bready, 1);
      chk("awvalid_after", awvalid, 0);
      bvalid = 1'b1; bresp = v.resp;
      @(negedge clock);
      bvalid = 1'b0; bresp = 2'd0;
    end
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clock); n++; end
    chk("out_valid", out_valid, 1);
    e = sb.pop_front();
    chk("latency", cyc - t0, e.lat);
    chk("out_rdata", out_rdata, e.rdata);
    chk("out_err", out_err, e.err);
    chk("in_ready_done", in_ready, 0);
    held = out_rdata;
    for (int i = 0; i < v.out_dly; i++) begin
      @(negedge clock);
      chk("hold_valid", out_valid, 1);
      chk("hold_rdata", out_rdata, held);
      chk("hold_err", out_err, e.err);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clock);
    out_ready = 1'b0;
    chk("out_valid_clear", out_valid, 0);
    chk("in_ready_next", in_ready, 1);
  endtask

  initial begin
    //          wen f3      addr          wdata         rdata         resp  ar aw w od size  e_wdata       strb     e_rdata       err mis
    vecs[0]  = '{0, 3'b000, 32'h8000_0003, 32'h0,        32'h80FF_1234, 2'b00, 1, 0, 0, 0, 3'd0, 32'h0,        4'b0000, 32'hFFFF_FF80, 0, 0};
    vecs[1]  = '{0, 3'b101, 32'h8000_0002, 32'h0,        32'hBEEF_0000, 2'b00, 0, 0, 0, 0, 3'd1, 32'h0,        4'b0000, 32'h0000_BEEF, 0, 0};
    vecs[2]  = '{0, 3'b010, 32'h0200_0048, 32'h0,        32'h1234_5678, 2'b00, 0, 0, 0, 0, 3'd2, 32'h0,        4'b0000, 32'h1234_5678, 0, 0};
    vecs[3]  = '{0, 3'b001, 32'h0000_0000, 32'h0,        32'h0000_8001, 2'b00, 0, 0, 0, 0, 3'd1, 32'h0,        4'b0000, 32'hFFFF_8001, 0, 0};
    vecs[4]  = '{0, 3'b100, 32'h0000_0001, 32'h0,        32'h0000_F100, 2'b00, 0, 0, 0, 0, 3'd0, 32'h0,        4'b0000, 32'h0000_00F1, 0, 0};
    vecs[5]  = '{1, 3'b000, 32'h8000_0001, 32'h0000_00AB, 32'h0,        2'b00, 0, 0, 0, 0, 3'd0, 32'h0000_AB00, 4'b0010, 32'h0,        0, 0};
    vecs[6]  = '{1, 3'b001, 32'h8000_0002, 32'h0000_CAFE, 32'h0,        2'b00, 0, 0, 0, 0, 3'd1, 32'hCAFE_0000, 4'b1100, 32'h0,        0, 0};
    vecs[7]  = '{1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0,        2'b00, 0, 0, 0, 0, 3'd2, 32'hDEAD_BEEF, 4'b1111, 32'h0,        0, 0};
    vecs[8]  = '{1, 3'b010, 32'h8000_0020, 32'h0123_4567, 32'h0,        2'b00, 0, 3, 0, 0, 3'd2, 32'h0123_4567, 4'b1111, 32'h0,        0, 0};
    vecs[9]  = '{0, 3'b010, 32'h8000_0002, 32'h0,        32'h0,        2'b00, 0, 0, 0, 0, 3'd2, 32'h0,        4'b0000, 32'h0,        1, 1};
    vecs[10] = '{0, 3'b010, 32'h8000_0000, 32'h0,        32'h1111_2222, 2'b10, 0, 0, 0, 0, 3'd2, 32'h0,        4'b0000, 32'h1111_2222, 1, 0};
    vecs[11] = '{1, 3'b001, 32'h0000_0001, 32'h0000_1234, 32'h0,        2'b00, 0, 0, 0, 0, 3'd1, 32'h0,        4'b0000, 32'h0,        1, 1};
    vecs[12] = '{1, 3'b000, 32'h0000_0003, 32'h0000_00FF, 32'h0,        2'b11, 0, 0, 0, 0, 3'd0, 32'hFF00_0000, 4'b1000, 32'h0,        1, 0};
    vecs[13] = '{0, 3'b101, 32'h0000_0002, 32'h0,        32'h7FFF_0000, 2'b00, 0, 0, 0, 5, 3'd1, 32'h0,        4'b0000, 32'h0000_7FFF, 0, 0};
    vecs[14] = '{1, 3'b001, 32'h1000_0000, 32'h1234_5678, 32'h0,        2'b00, 0, 0, 2, 0, 3'd1, 32'h1234_5678, 4'b0011, 32'h0,        0, 0};

    repeat (2) @(negedge clock);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready, out_err}, 0);
    chk("rst_out_rdata", out_rdata, 0);
    chk("rst_addr", araddr | awaddr | wdata | {28'd0, wstrb}, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 15; i++) run_op(vecs[i]);

    // Reset arriving while the read data phase is outstanding.
    in_valid = 1'b1; in_wen = 1'b0; in_funct3 = 3'b010; in_addr = 32'h8000_0040;
    @(negedge clock);
    in_valid = 1'b0;
    chk("rr_arvalid", arvalid, 1);
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    chk("rr_rready", rready, 1);
    #2 reset = 1'b1;
    #1;
    chk("rr_rready_rst", rready, 0);
    chk("rr_valids_rst", {arvalid, awvalid, wvalid, bready, out_valid, out_err}, 0);
    chk("rr_in_ready_rst", in_ready, 1);
    chk("rr_araddr_rst", araddr, 0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("rr_in_ready_after", in_ready, 1);
    run_op(vecs[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
